// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
//
// Boot-time instruction loader. Receives a length-prefixed byte stream and
// writes it, one 32-bit little-endian word per four bytes, into instruction
// memory starting at word address 0. The core is held in reset (cpu_hold)
// until a load completes successfully.
//
// Stream format:
//   byte 0      : len[7:0]
//   byte 1      : len[10:8] in bits 2:0 (bits 7:3 ignored)
//   len*4 bytes : instruction words, least significant byte first
//   [1 byte]    : mod-256 sum of all data bytes (checksum build only)
//
// len may be 0..1024 words. A longer length, an idle gap of TIMEOUT_CYCLES
// cycles, or (checksum build) a bad checksum ends the load in ERROR.
//
// Build option:
//   INST_LOADER_CHECKSUM_EN - when defined, adds the trailing checksum byte
//                             and the CSUM state. Undefined by default.
//
// Parameters:
//   TIMEOUT_CYCLES - idle cycles tolerated between accepted bytes (>= 2).
//
// Ports:
//   clk           clock
//   rst           asynchronous active-high reset
//   start         one-cycle pulse that begins a load (ignored while busy)
//   in_valid      byte-stream valid
//   in_data[7:0]  byte-stream data
//   in_ready      byte accepted on an edge where in_valid && in_ready
//   mem_we        instruction-memory write enable (one cycle per word)
//   mem_addr[9:0] instruction-memory word address (held between writes)
//   mem_wdata[31:0] instruction-memory write data (held between writes)
//   words_loaded[10:0] words written during the current load
//   busy          load in progress
//   done          last load completed successfully
//   error         last load failed
//   cpu_hold      holds the core in reset while 1
// -----------------------------------------------------------------------------
module inst_loader #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic [10:0] words_loaded,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
);

  // Idle counter only needs to reach TIMEOUT_CYCLES-1: the cycle that would
  // make it TIMEOUT_CYCLES is the one that raises the error.
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [10:0]   MAX_LEN = 11'd1024;

`ifdef INST_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5,
    S_CSUM  = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_DATA  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;
`endif

  state_t         state;
  logic [7:0]     len_lo;
  logic [10:0]    len;
  logic [1:0]     lane;
  logic [23:0]    word_buf;
  logic [TW-1:0]  idle_cnt;

  logic           accept;
  logic [10:0]    hdr_len;
  logic [10:0]    wl_next;
  logic           last_word;
  logic           timeout_hit;

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]     csum;

  // Running checksum: plain mod-256 wrap of the byte sum.
  function automatic logic [7:0] csum_add(input logic [7:0] acc,
                                          input logic [7:0] b);
    csum_add = acc + b;
  endfunction
`endif

  assign accept      = in_valid && in_ready;
  assign hdr_len     = {in_data[2:0], len_lo};
  assign wl_next     = words_loaded + 11'd1;
  assign last_word   = (wl_next == len);
  // in_ready is 1 exactly in the byte-accepting states, so it doubles as
  // the "timeout counter is running" qualifier.
  assign timeout_hit = in_ready && !accept && (idle_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      mem_we       <= 1'b0;
      mem_addr     <= 10'd0;
      mem_wdata    <= 32'd0;
      words_loaded <= 11'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      in_ready     <= 1'b0;
      cpu_hold     <= 1'b1;
      len_lo       <= 8'd0;
      len          <= 11'd0;
      lane         <= 2'd0;
      word_buf     <= 24'd0;
      idle_cnt     <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum         <= 8'd0;
`endif
    end else begin
      mem_we <= 1'b0;

      if (in_ready) begin
        if (accept) idle_cnt <= '0;
        else        idle_cnt <= idle_cnt + TW'(1);
      end

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state        <= S_HDR0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 11'd0;
            lane         <= 2'd0;
            idle_cnt     <= '0;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
            in_ready     <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
            csum         <= 8'd0;
`endif
          end
        end

        S_HDR0: begin
          if (accept) begin
            len_lo <= in_data;
            state  <= S_HDR1;
          end
        end

        S_HDR1: begin
          if (accept) begin
            len <= hdr_len;
            if (hdr_len > MAX_LEN) begin
              state    <= S_ERROR;
              error    <= 1'b1;
              busy     <= 1'b0;
              cpu_hold <= 1'b1;
              in_ready <= 1'b0;
            end else if (hdr_len == 11'd0) begin
              state    <= S_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              cpu_hold <= 1'b0;
              in_ready <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            lane <= lane + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
            csum <= csum_add(csum, in_data);
`endif
            case (lane)
              2'd0: word_buf[7:0]   <= in_data;
              2'd1: word_buf[15:8]  <= in_data;
              2'd2: word_buf[23:16] <= in_data;
              default: begin
                // Fourth byte: the whole word is written on this same edge.
                mem_we       <= 1'b1;
                mem_addr     <= words_loaded[9:0];
                mem_wdata    <= {in_data, word_buf};
                words_loaded <= wl_next;
                if (last_word) begin
`ifdef INST_LOADER_CHECKSUM_EN
                  state <= S_CSUM;
`else
                  state    <= S_DONE;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  cpu_hold <= 1'b0;
                  in_ready <= 1'b0;
`endif
                end
              end
            endcase
          end
        end

`ifdef INST_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            busy     <= 1'b0;
            in_ready <= 1'b0;
            if (in_data == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              // Words already written stay in memory; the core stays held.
              state    <= S_ERROR;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end
`endif

        default: state <= S_IDLE;
      endcase

      // Idle timeout wins over anything above; only reachable on a cycle
      // with no accepted byte, so no write or header update is lost. Any
      // partial word in word_buf is simply abandoned.
      if (timeout_hit) begin
        state    <= S_ERROR;
        error    <= 1'b1;
        done     <= 1'b0;
        busy     <= 1'b0;
        cpu_hold <= 1'b1;
        in_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [10:0] words_loaded;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  inst_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .words_loaded (words_loaded),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .cpu_hold     (cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_mis = 0;
  int  we_count = 0;

  // Scoreboard: every memory write must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_t e;
      we_count++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_write: addr=%0d data=%h, no write expected", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          n_mis++;
          $display("FAIL write: got %0d:%h want %0d:%h", mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
    $fatal(1, "watchdog");
  end

  task automatic drive_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL in_ready_wait: in_ready=%b want 1 (byte %h)", in_ready, b);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load(input logic [31:0] w[$], input int g, input bit bad_csum);
    logic [10:0] n;
    logic [7:0]  sum;
    logic [7:0]  cbyte;
    wr_t e;
    n   = 11'(w.size());
    sum = 8'd0;
    drive_byte(n[7:0]);
    if (g > 0) gap(g);
    drive_byte({5'b0, n[10:8]});
    foreach (w[i]) begin
      e.addr = 10'(i);
      e.data = w[i];
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++) begin
        if (g > 0) gap(g);
        drive_byte(w[i][8*k +: 8]);
        sum = sum + w[i][8*k +: 8];
      end
    end
    cbyte = bad_csum ? sum + 8'd1 : sum;
`ifdef INST_LOADER_CHECKSUM_EN
    if (g > 0) gap(g);
    drive_byte(cbyte);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (mem_we !== 1'b0)        begin n_mis++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 10'd0)     begin n_mis++; $display("FAIL rst_mem_addr: got %0d want 0", mem_addr); end
    n_cmp++; if (mem_wdata !== 32'd0)    begin n_mis++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    n_cmp++; if (words_loaded !== 11'd0) begin n_mis++; $display("FAIL rst_words: got %0d want 0", words_loaded); end
    n_cmp++; if (busy !== 1'b0)          begin n_mis++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)          begin n_mis++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (error !== 1'b0)         begin n_mis++; $display("FAIL rst_error: got %b want 0", error); end
    n_cmp++; if (in_ready !== 1'b0)      begin n_mis++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (cpu_hold !== 1'b1)      begin n_mis++; $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); end
    @(negedge clk);
    rst = 1'b0;
    gap(2);
    n_cmp++; if (busy !== 1'b0 || cpu_hold !== 1'b1) begin n_mis++; $display("FAIL idle_after_rst: busy=%b cpu_hold=%b want 0/1", busy, cpu_hold); end
  endtask

  task automatic test_basic();
    logic [31:0] w[$];
    int base;
    w = '{32'h12345678, 32'hDEADBEEF};
    base = we_count;
    pulse_start();
    n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0)
      begin n_mis++; $display("FAIL start_flags: busy=%b in_ready=%b cpu_hold=%b done=%b want 1/1/1/0", busy, in_ready, cpu_hold, done); end
    load(w, 0, 1'b0);
    n_cmp++; if (done !== 1'b1)          begin n_mis++; $display("FAIL basic_done: got %b want 1", done); end
    n_cmp++; if (error !== 1'b0)         begin n_mis++; $display("FAIL basic_error: got %b want 0", error); end
    n_cmp++; if (busy !== 1'b0)          begin n_mis++; $display("FAIL basic_busy: got %b want 0", busy); end
    n_cmp++; if (cpu_hold !== 1'b0)      begin n_mis++; $display("FAIL basic_cpu_hold: got %b want 0", cpu_hold); end
    n_cmp++; if (words_loaded !== 11'd2) begin n_mis++; $display("FAIL basic_words: got %0d want 2", words_loaded); end
    n_cmp++; if (in_ready !== 1'b0)      begin n_mis++; $display("FAIL basic_in_ready: got %b want 0", in_ready); end
    gap(3);
    n_cmp++; if (exp_q.size() != 0)      begin n_mis++; $display("FAIL basic_pending: %0d writes missing, want 0", exp_q.size()); end
    n_cmp++; if (we_count - base != 2)   begin n_mis++; $display("FAIL basic_we_count: got %0d want 2", we_count - base); end
    n_cmp++; if (mem_addr !== 10'd1 || mem_wdata !== 32'hDEADBEEF)
      begin n_mis++; $display("FAIL basic_hold: got %0d:%h want 1:deadbeef", mem_addr, mem_wdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[$];
    int base;
    w = '{32'h12345678, 32'hDEADBEEF};
    base = we_count;
    pulse_start();
    load(w, 1, 1'b0);
    n_cmp++; if (done !== 1'b1 || words_loaded !== 11'd2)
      begin n_mis++; $display("FAIL toggle_end: done=%b words=%0d want 1/2", done, words_loaded); end
    gap(3);
    n_cmp++; if (we_count - base != 2 || exp_q.size() != 0)
      begin n_mis++; $display("FAIL toggle_we_count: got %0d pending %0d want 2/0", we_count - base, exp_q.size()); end
  endtask

  task automatic test_header_bounds();
    int base;
    base = we_count;
    pulse_start();
    drive_byte(8'h01);
    drive_byte(8'h04);
    n_cmp++; if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b1)
      begin n_mis++; $display("FAIL len1025: error=%b done=%b busy=%b cpu_hold=%b want 1/0/0/1", error, done, busy, cpu_hold); end
    gap(3);
    n_cmp++; if (we_count != base) begin n_mis++; $display("FAIL len1025_writes: got %0d want 0", we_count - base); end
    pulse_start();
    n_cmp++; if (error !== 1'b0) begin n_mis++; $display("FAIL restart_clears_error: got %b want 0", error); end
    drive_byte(8'h00);
    drive_byte(8'h00);
    n_cmp++; if (done !== 1'b1 || words_loaded !== 11'd0 || cpu_hold !== 1'b0 || error !== 1'b0)
      begin n_mis++; $display("FAIL len0: done=%b words=%0d cpu_hold=%b error=%b want 1/0/0/0", done, words_loaded, cpu_hold, error); end
  endtask

  task automatic test_len_max();
    logic [31:0] w[$];
    for (int i = 0; i < 1024; i++) w.push_back((32'(i) * 32'h01030507) ^ 32'h5A3C0F96);
    pulse_start();
    load(w, 0, 1'b0);
    n_cmp++; if (done !== 1'b1 || words_loaded !== 11'd1024)
      begin n_mis++; $display("FAIL len_max: done=%b words=%0d want 1/1024", done, words_loaded); end
    gap(3);
    n_cmp++; if (mem_addr !== 10'd1023 || exp_q.size() != 0)
      begin n_mis++; $display("FAIL len_max_addr: addr=%0d pending=%0d want 1023/0", mem_addr, exp_q.size()); end
  endtask

  task automatic test_timeout();
    logic [31:0] w[$];
    int base;
    base = we_count;
    pulse_start();
    drive_byte(8'h02);
    drive_byte(8'h00);
    drive_byte(8'h11);
    drive_byte(8'h22);
    gap(15);
    n_cmp++; if (error !== 1'b0 || busy !== 1'b1)
      begin n_mis++; $display("FAIL timeout_early: error=%b busy=%b want 0/1", error, busy); end
    gap(1);
    n_cmp++; if (error !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0)
      begin n_mis++; $display("FAIL timeout: error=%b busy=%b cpu_hold=%b done=%b want 1/0/1/0", error, busy, cpu_hold, done); end
    gap(3);
    n_cmp++; if (we_count != base) begin n_mis++; $display("FAIL timeout_writes: got %0d want 0", we_count - base); end
    w = '{32'hCAFEF00D, 32'h0BADBEEF};
    pulse_start();
    load(w, 0, 1'b0);
    gap(3);
    n_cmp++; if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 11'd2 || exp_q.size() != 0)
      begin n_mis++; $display("FAIL timeout_reload: done=%b error=%b words=%0d pending=%0d want 1/0/2/0", done, error, words_loaded, exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    wr_t e;
    int base;
    logic [31:0] d;
    base = we_count;
    pulse_start();
    drive_byte(8'h08);
    drive_byte(8'h00);
    for (int i = 0; i < 5; i++) begin
      d = 32'hA0B0C0D0 + 32'(i) * 32'h11111111;
      e.addr = 10'(i);
      e.data = d;
      exp_q.push_back(e);
      for (int k = 0; k < 4; k++) drive_byte(d[8*k +: 8]);
      if (i == 1) begin
        pulse_start();
        n_cmp++; if (busy !== 1'b1 || words_loaded !== 11'd2 || in_ready !== 1'b1)
          begin n_mis++; $display("FAIL start_ignored: busy=%b words=%0d in_ready=%b want 1/2/1", busy, words_loaded, in_ready); end
      end
    end
    drive_byte(8'h55);
    drive_byte(8'h66);
    drive_byte(8'h77);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_wdata !== 32'd0 || words_loaded !== 11'd0)
      begin n_mis++; $display("FAIL mid_rst_mem: we=%b addr=%0d data=%h words=%0d want 0/0/0/0", mem_we, mem_addr, mem_wdata, words_loaded); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || in_ready !== 1'b0 || cpu_hold !== 1'b1)
      begin n_mis++; $display("FAIL mid_rst_flags: busy=%b done=%b error=%b in_ready=%b cpu_hold=%b want 0/0/0/0/1", busy, done, error, in_ready, cpu_hold); end
    gap(3);
    @(negedge clk);
    rst = 1'b0;
    gap(4);
    n_cmp++; if (we_count - base != 5 || exp_q.size() != 0)
      begin n_mis++; $display("FAIL mid_rst_writes: got %0d pending %0d want 5/0", we_count - base, exp_q.size()); end
  endtask

`ifdef INST_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [31:0] w[$];
    int base;
    w = '{32'h04030201};
    pulse_start();
    load(w, 0, 1'b0);
    n_cmp++; if (done !== 1'b1 || error !== 1'b0)
      begin n_mis++; $display("FAIL csum_good: done=%b error=%b want 1/0", done, error); end
    base = we_count;
    pulse_start();
    load(w, 0, 1'b1);
    n_cmp++; if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1)
      begin n_mis++; $display("FAIL csum_bad: error=%b done=%b cpu_hold=%b want 1/0/1", error, done, cpu_hold); end
    gap(3);
    n_cmp++; if (we_count - base != 1 || exp_q.size() != 0 || mem_wdata !== 32'h04030201)
      begin n_mis++; $display("FAIL csum_bad_write: writes=%0d data=%h want 1/04030201", we_count - base, mem_wdata); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_header_bounds();
    test_timeout();
    test_len_max();
`ifdef INST_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
